// File: rtl/inst_encoder.sv
// RV32I instruction encoder. Stage 1 captures a request and flags illegal
// ones; stage 2 assembles the machine word and holds it until the consumer
// takes it. rdy_in freezes everything except a synchronous reset.
module inst_encoder (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        rdy_in,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [5:0]  order,
   input  logic [31:0] rd,
   input  logic [31:0] rs1,
   input  logic [31:0] rs2,
   input  logic [31:0] imm,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] inst,
   output logic        err,
   output logic [15:0] enc_count
);

   // Shared operation codes, LUI = 0 through BGEU = 36; 37..63 are undefined.
   localparam logic [5:0] OP_LUI   = 6'd0,  OP_AUIPC = 6'd1,  OP_JAL   = 6'd2,  OP_JALR  = 6'd3;
   localparam logic [5:0] OP_LB    = 6'd4,  OP_LH    = 6'd5,  OP_LW    = 6'd6,  OP_LBU   = 6'd7;
   localparam logic [5:0] OP_LHU   = 6'd8,  OP_SB    = 6'd9,  OP_SH    = 6'd10, OP_SW    = 6'd11;
   localparam logic [5:0] OP_ADDI  = 6'd12, OP_SLTI  = 6'd13, OP_SLTIU = 6'd14, OP_XORI  = 6'd15;
   localparam logic [5:0] OP_ORI   = 6'd16, OP_ANDI  = 6'd17, OP_SLLI  = 6'd18, OP_SRLI  = 6'd19;
   localparam logic [5:0] OP_SRAI  = 6'd20, OP_ADD   = 6'd21, OP_SUB   = 6'd22, OP_SLL   = 6'd23;
   localparam logic [5:0] OP_SLT   = 6'd24, OP_SLTU  = 6'd25, OP_XOR   = 6'd26, OP_SRL   = 6'd27;
   localparam logic [5:0] OP_SRA   = 6'd28, OP_OR    = 6'd29, OP_AND   = 6'd30, OP_BEQ   = 6'd31;
   localparam logic [5:0] OP_BNE   = 6'd32, OP_BLT   = 6'd33, OP_BGE   = 6'd34, OP_BLTU  = 6'd35;
   localparam logic [5:0] OP_BGEU  = 6'd36;

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [31:0] NOP_WORD  = 32'h0000_0013;

   typedef enum logic [2:0] {FMT_U, FMT_J, FMT_I, FMT_S, FMT_B, FMT_R, FMT_X} fmt_e;

   function automatic fmt_e fmt_of(input logic [5:0] o);
      if (o <= OP_AUIPC)                  return FMT_U;
      else if (o == OP_JAL)               return FMT_J;
      else if (o <= OP_LHU)               return FMT_I;
      else if (o <= OP_SW)                return FMT_S;
      else if (o <= OP_SRAI)              return FMT_I;
      else if (o <= OP_AND)               return FMT_R;
      else if (o <= OP_BGEU)              return FMT_B;
      else                                return FMT_X;
   endfunction

   function automatic logic is_shift(input logic [5:0] o);
      return (o == OP_SLLI) || (o == OP_SRLI) || (o == OP_SRAI);
   endfunction

   logic        s1_v_q, s1_v_d;
   logic [5:0]  s1_order_q, s1_order_d;
   fmt_e        s1_fmt_q, s1_fmt_d;
   logic [4:0]  s1_rd_q, s1_rd_d, s1_rs1_q, s1_rs1_d, s1_rs2_q, s1_rs2_d;
   logic [31:0] s1_imm_q, s1_imm_d;
   logic        s1_err_q, s1_err_d;
   logic        s2_v_q, s2_v_d;
   logic [31:0] inst_q, inst_d;
   logic        err_q, err_d;
   logic [15:0] cnt_q, cnt_d;

   fmt_e        chk_fmt;
   logic        chk_err, reg_bad, imm_bad;
   logic [6:0]  opc, f7;
   logic [2:0]  f3;
   logic [31:0] asm_word;
   logic        s2_free, s1_move, in_fire, out_fire;

   assign s2_free  = !s2_v_q || out_ready;
   assign s1_move  = rdy_in && s1_v_q && s2_free;
   assign in_ready = rdy_in && (!s1_v_q || s2_free);
   assign in_fire  = in_valid && in_ready;
   assign out_fire = rdy_in && s2_v_q && out_ready;

   assign out_valid = s2_v_q;
   assign inst      = inst_q;
   assign err       = err_q;
   assign enc_count = cnt_q;

   // Legality of the incoming request; only fields the format uses are checked.
   always_comb begin
      chk_fmt = fmt_of(order);
      reg_bad = 1'b0;
      imm_bad = 1'b0;
      case (chk_fmt)
         FMT_U: begin
            reg_bad = |rd[31:5];
            imm_bad = |imm[11:0];
         end
         FMT_J: begin
            reg_bad = |rd[31:5];
            imm_bad = !((&imm[31:20]) || !(|imm[31:20])) || imm[0];
         end
         FMT_I: begin
            reg_bad = (|rd[31:5]) || (|rs1[31:5]);
            // Shift amounts are unsigned 0..31, so any negative value is illegal too.
            if (is_shift(order)) imm_bad = |imm[31:5];
            else                 imm_bad = !((&imm[31:11]) || !(|imm[31:11]));
         end
         FMT_S: begin
            reg_bad = (|rs1[31:5]) || (|rs2[31:5]);
            imm_bad = !((&imm[31:11]) || !(|imm[31:11]));
         end
         FMT_B: begin
            reg_bad = (|rs1[31:5]) || (|rs2[31:5]);
            imm_bad = !((&imm[31:12]) || !(|imm[31:12])) || imm[0];
         end
         FMT_R: begin
            reg_bad = (|rd[31:5]) || (|rs1[31:5]) || (|rs2[31:5]);
         end
         default: ;
      endcase
      chk_err = (chk_fmt == FMT_X) || reg_bad || imm_bad;
   end

   // Opcode / funct3 / funct7 for the operation held in stage 1.
   always_comb begin
      opc = OPC_OPIMM;
      f3  = 3'd0;
      f7  = 7'h00;
      case (s1_order_q)
         OP_LUI:   opc = OPC_LUI;
         OP_AUIPC: opc = OPC_AUIPC;
         OP_JAL:   opc = OPC_JAL;
         OP_JALR:  opc = OPC_JALR;
         OP_LB:    begin opc = OPC_LOAD;  f3 = 3'd0; end
         OP_LH:    begin opc = OPC_LOAD;  f3 = 3'd1; end
         OP_LW:    begin opc = OPC_LOAD;  f3 = 3'd2; end
         OP_LBU:   begin opc = OPC_LOAD;  f3 = 3'd4; end
         OP_LHU:   begin opc = OPC_LOAD;  f3 = 3'd5; end
         OP_SB:    begin opc = OPC_STORE; f3 = 3'd0; end
         OP_SH:    begin opc = OPC_STORE; f3 = 3'd1; end
         OP_SW:    begin opc = OPC_STORE; f3 = 3'd2; end
         OP_ADDI:  f3 = 3'd0;
         OP_SLTI:  f3 = 3'd2;
         OP_SLTIU: f3 = 3'd3;
         OP_XORI:  f3 = 3'd4;
         OP_ORI:   f3 = 3'd6;
         OP_ANDI:  f3 = 3'd7;
         OP_SLLI:  f3 = 3'd1;
         OP_SRLI:  f3 = 3'd5;
         OP_SRAI:  begin f3 = 3'd5; f7 = 7'h20; end
         OP_ADD:   opc = OPC_OP;
         OP_SUB:   begin opc = OPC_OP; f7 = 7'h20; end
         OP_SLL:   begin opc = OPC_OP; f3 = 3'd1; end
         OP_SLT:   begin opc = OPC_OP; f3 = 3'd2; end
         OP_SLTU:  begin opc = OPC_OP; f3 = 3'd3; end
         OP_XOR:   begin opc = OPC_OP; f3 = 3'd4; end
         OP_SRL:   begin opc = OPC_OP; f3 = 3'd5; end
         OP_SRA:   begin opc = OPC_OP; f3 = 3'd5; f7 = 7'h20; end
         OP_OR:    begin opc = OPC_OP; f3 = 3'd6; end
         OP_AND:   begin opc = OPC_OP; f3 = 3'd7; end
         OP_BEQ:   begin opc = OPC_BRANCH; f3 = 3'd0; end
         OP_BNE:   begin opc = OPC_BRANCH; f3 = 3'd1; end
         OP_BLT:   begin opc = OPC_BRANCH; f3 = 3'd4; end
         OP_BGE:   begin opc = OPC_BRANCH; f3 = 3'd5; end
         OP_BLTU:  begin opc = OPC_BRANCH; f3 = 3'd6; end
         OP_BGEU:  begin opc = OPC_BRANCH; f3 = 3'd7; end
         default: ;
      endcase
   end

   // Word assembly; illegal requests become a NOP.
   always_comb begin
      asm_word = NOP_WORD;
      case (s1_fmt_q)
         FMT_U: asm_word = {s1_imm_q[31:12], s1_rd_q, opc};
         FMT_J: asm_word = {s1_imm_q[20], s1_imm_q[10:1], s1_imm_q[11], s1_imm_q[19:12], s1_rd_q, opc};
         FMT_I: begin
            if (is_shift(s1_order_q)) asm_word = {f7, s1_imm_q[4:0], s1_rs1_q, f3, s1_rd_q, opc};
            else                      asm_word = {s1_imm_q[11:0], s1_rs1_q, f3, s1_rd_q, opc};
         end
         FMT_S: asm_word = {s1_imm_q[11:5], s1_rs2_q, s1_rs1_q, f3, s1_imm_q[4:0], opc};
         FMT_B: asm_word = {s1_imm_q[12], s1_imm_q[10:5], s1_rs2_q, s1_rs1_q, f3,
                            s1_imm_q[4:1], s1_imm_q[11], opc};
         FMT_R: asm_word = {f7, s1_rs2_q, s1_rs1_q, f3, s1_rd_q, opc};
         default: ;
      endcase
      if (s1_err_q) asm_word = NOP_WORD;
   end

   // Pipeline advance; nothing moves while rdy_in is low.
   always_comb begin
      s1_v_d     = s1_v_q;
      s1_order_d = s1_order_q;
      s1_fmt_d   = s1_fmt_q;
      s1_rd_d    = s1_rd_q;
      s1_rs1_d   = s1_rs1_q;
      s1_rs2_d   = s1_rs2_q;
      s1_imm_d   = s1_imm_q;
      s1_err_d   = s1_err_q;
      s2_v_d     = s2_v_q;
      inst_d     = inst_q;
      err_d      = err_q;
      cnt_d      = cnt_q;
      if (s1_move) begin
         s2_v_d = 1'b1;
         inst_d = asm_word;
         err_d  = s1_err_q;
      end else if (out_fire) begin
         s2_v_d = 1'b0;
      end
      if (in_fire) begin
         s1_v_d     = 1'b1;
         s1_order_d = order;
         s1_fmt_d   = chk_fmt;
         s1_rd_d    = rd[4:0];
         s1_rs1_d   = rs1[4:0];
         s1_rs2_d   = rs2[4:0];
         s1_imm_d   = imm;
         s1_err_d   = chk_err;
      end else if (s1_move) begin
         s1_v_d = 1'b0;
      end
      if (out_fire) cnt_d = cnt_q + 16'd1;
   end

   // Control and output registers, cleared by reset regardless of rdy_in.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         s1_v_q <= 1'b0;
         s2_v_q <= 1'b0;
         inst_q <= 32'h0;
         err_q  <= 1'b0;
         cnt_q  <= 16'h0;
      end else begin
         s1_v_q <= s1_v_d;
         s2_v_q <= s2_v_d;
         inst_q <= inst_d;
         err_q  <= err_d;
         cnt_q  <= cnt_d;
      end
   end

   // Stage-1 payload, only meaningful while s1_v_q is set.
   always_ff @(posedge clk_in) begin
      s1_order_q <= s1_order_d;
      s1_fmt_q   <= s1_fmt_d;
      s1_rd_q    <= s1_rd_d;
      s1_rs1_q   <= s1_rs1_d;
      s1_rs2_q   <= s1_rs2_d;
      s1_imm_q   <= s1_imm_d;
      s1_err_q   <= s1_err_d;
   end

endmodule

// File: doc/inst_encoder.md
INST_ENCODER -- requirements
Module: inst_encoder

Interface
REQ-001 SHALL have one clock; reset is synchronous and active-high.
REQ-002 clk_in  input  1  rising-edge clock.
REQ-003 rst_in  input  1  synchronous active-high reset.
REQ-004 rdy_in  input  1  global enable; 0 freezes all state.
REQ-005 in_valid  input  1  request valid.
REQ-006 in_ready  output  1  encoder can accept a request this cycle.
REQ-007 order  input  6  operation code from the shared opcode defines (LUI..BGEU, 37 codes).
REQ-008 rd, rs1, rs2  input  32 each  register indices; only [4:0] legal.
REQ-009 imm  input  32  sign-extended immediate, the same form the decoder emits.
REQ-010 out_valid  output  1  encoded word valid.
REQ-011 out_ready  input  1  consumer accepts the word.
REQ-012 inst  output  32  RV32I machine word.
REQ-013 err  output  1  request was illegal, qualified by out_valid.
REQ-014 enc_count  output  16  count of words accepted by the consumer.

Function
REQ-015 The block SHALL be a 2-stage valid/ready pipeline: S1 registers the request and checks legality; S2 assembles and holds the output.
REQ-016 A transfer SHALL occur on an edge with valid=1 and ready=1 and rdy_in=1, with no other transfers.
REQ-017 in_ready SHALL be rdy_in AND (S1 empty OR S1 advancing); S1 advances when S2 is empty or out_ready=1.
REQ-018 Latency SHALL be 2 cycles from input transfer to out_valid; full throughput SHALL be 1 word per cycle.
REQ-019 Outputs SHALL stay stable while out_valid=1 and out_ready=0.
REQ-020 The format per order SHALL be: U for LUI/AUIPC (imm[31:12]); J for JAL (imm[20:1]); I for JALR, loads, and ALU-immediate operations; S for stores; B for branches; R for register-register operations.
REQ-021 The opcode, funct3, and funct7 values SHALL be the exact inverses of the decoder table.
REQ-022 SRAI SHALL set funct7=0x20. SLLI and SRLI SHALL set funct7=0x00. Shift amount SHALL be imm[4:0].
REQ-023 Fields not used by a format SHALL be ignored, not checked.
REQ-024 err SHALL be 1 on any of the following:
  - undefined order;
  - a used register index > 31;
  - an I or S imm outside [-2048, 2047];
  - a B imm outside [-4096, 4094] or with bit0 set;
  - a J imm outside [-2^20, 2^20-2] or with bit0 set;
  - a U imm with [11:0] nonzero;
  - a shift imm > 31.
REQ-025 When err=1, inst SHALL be 0x00000013 (NOP).
REQ-026 enc_count SHALL increment on each output transfer (err or not) and SHALL wrap from 0xFFFF to 0.
REQ-027 Simultaneous input and output transfers with both stages full SHALL advance both stages without loss or duplication.

Reset
REQ-028 On rst_in=1 at an edge, the following SHALL clear regardless of rdy_in: S1 and S2 valid, out_valid, err, inst=0, enc_count=0.
REQ-029 Reset mid-operation SHALL drop all in-flight requests.
REQ-030 in_ready SHALL be 1 in the first cycle after reset if rdy_in=1.

Verification
REQ-031 ADDI rd=1 rs1=0 imm=0xFFFFFFFF SHALL produce inst=0xFFF00093 and err=0 two cycles later.
REQ-032 LUI rd=5 imm=0x12345000 SHALL produce 0x123452B7. SW rs1=1 rs2=2 imm=8 SHALL produce 0x0020A423.
REQ-033 BEQ rs1=1 rs2=2 imm=0xFFFFFFFC SHALL produce 0xFE208EE3. The same request with imm=3 SHALL produce err=1 and inst=0x00000013.
REQ-034 With 3 back-to-back requests and out_ready held 0, the output SHALL hold word 1, in_ready SHALL drop after the second request is accepted, and releasing out_ready SHALL drain words in order with none lost.
REQ-035 Driving rdy_in=0 for 4 cycles mid-stream SHALL leave all state frozen. Asserting rst_in with both stages full SHALL give out_valid=0 and enc_count=0 on the next cycle.
REQ-036 After 65537 accepted outputs, enc_count SHALL read 1.
